// File: rtl/mycpu_arb_pkg.sv
// mycpu_arb_pkg: shared types and helpers for the SRAM request arbiter.
// In-flight record, channel-id width helper and round-robin reset value.
package mycpu_arb_pkg;

  localparam int CH_ID_MAX_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [CH_ID_MAX_W-1:0] ch_id;
    logic                   is_wr;
  } inflight_t;

  function automatic int ch_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Last-granted pointer starts at the top channel so channel 0 wins first.
  function automatic int rr_ptr_rst(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/mycpu_resp_fifo.sv
// mycpu_resp_fifo: single-clock response FIFO, DATA_W x DEPTH.
// Pointers wrap explicitly so non-power-of-2 depths work; head reads 0 when empty.
module mycpu_resp_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mycpu_sram_arbiter.sv
// mycpu_sram_arbiter: merges NUM_CH req/addr_ok/data_ok channels onto one SRAM port.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module mycpu_sram_arbiter
  import mycpu_arb_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RESP_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_wr,
  input  logic [NUM_CH*DATA_W/8-1:0]   ch_wstrb,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
  output logic [NUM_CH-1:0]            ch_addr_ok,
  output logic [NUM_CH-1:0]            ch_data_ok,
  output logic [NUM_CH*DATA_W-1:0]     ch_rdata,
  input  logic [NUM_CH-1:0]            ch_rready,
  output logic                         mem_en,
  output logic [DATA_W/8-1:0]          mem_wen,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int SW      = DATA_W / 8;
  localparam int CH_ID_W = ch_id_w(NUM_CH);
  localparam int CNT_W   = $clog2(RESP_DEPTH + 1);

  inflight_t          inflight;
  logic [NUM_CH-1:0]  elig;
  logic [NUM_CH-1:0]  gnt;
  logic [NUM_CH-1:0]  hit;
  logic [NUM_CH-1:0]  pop;
  logic [NUM_CH-1:0]  fifo_empty;
  logic [NUM_CH-1:0]  fifo_full;
  logic [CNT_W-1:0]   fifo_cnt [NUM_CH];
  logic [DATA_W-1:0]  push_data;
  logic               gnt_any;
  logic               gnt_wr;
  logic [CH_ID_W-1:0] gnt_id;

  // Credit check: a same-cycle pop frees a slot for the entry now in flight.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]  = inflight.valid
              & (inflight.ch_id == CH_ID_MAX_W'(i));
      elig[i] = ch_req[i] & ~rst
              & ~(fifo_full[i] & ~pop[i])
              & ~(hit[i] & ((fifo_cnt[i] - CNT_W'(pop[i]))
                            == CNT_W'(RESP_DEPTH - 1)));
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_any = 1'b1;
        gnt_id  = CH_ID_W'(i);
      end
    end
  end
`else
  localparam int RR_PTR_RST = rr_ptr_rst(NUM_CH);

  logic [CH_ID_W-1:0] rr_ptr;

  // Round-robin: search from rr_ptr+1; nearest eligible is assigned last.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (elig[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = CH_ID_W'(idx);
      end
    end
  end

  // Remember the last granted channel; hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rr_ptr <= CH_ID_W'(RR_PTR_RST);
    else if (gnt_any) rr_ptr <= gnt_id;
  end
`endif

  // Steer the granted channel onto the SRAM port; idle drives zeros.
  always_comb begin
    gnt       = '0;
    gnt_wr    = 1'b0;
    mem_en    = gnt_any;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt[i] = gnt_any & (gnt_id == CH_ID_W'(i));
      if (gnt[i]) begin
        gnt_wr    = ch_wr[i];
        mem_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = ch_wdata[i*DATA_W +: DATA_W];
        mem_wen   = ch_wr[i] ? ch_wstrb[i*SW +: SW] : '0;
      end
    end
  end

  assign ch_addr_ok = gnt;

  // In-flight stage: remembers whose SRAM beat returns next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      inflight.valid <= gnt_any;
      inflight.ch_id <= CH_ID_MAX_W'(gnt_id);
      inflight.is_wr <= gnt_any & gnt_wr;
    end
  end

  assign push_data = inflight.is_wr ? '0 : mem_rdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    assign pop[g]        = ~fifo_empty[g] & ch_rready[g];
    assign ch_data_ok[g] = ~fifo_empty[g];

    mycpu_resp_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RESP_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (hit[g]),
      .pop   (pop[g]),
      .wdata (push_data),
      .rdata (ch_rdata[g*DATA_W +: DATA_W]),
      .count (fifo_cnt[g]),
      .empty (fifo_empty[g]),
      .full  (fifo_full[g])
    );
  end

endmodule

// File: tb/tb_mycpu_sram_arbiter.sv
// tb_mycpu_sram_arbiter: directed vectors for the 2-channel arbiter
// plus a 3-channel, depth-3 instance for in-order streaming.
module tb_mycpu_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  req, wr, rready, aok, dok;
  logic [7:0]  wstrb;
  logic [63:0] addr, wdata, rdata;
  logic        men;
  logic [3:0]  wen;
  logic [31:0] maddr, mwdata, mrdata;

  logic [2:0]  req3, wr3, rready3, aok3, dok3;
  logic [11:0] wstrb3;
  logic [95:0] addr3, wdata3, rdata3;
  logic        men3;
  logic [3:0]  wen3;
  logic [31:0] maddr3, mwdata3, mrdata3;

  mycpu_sram_arbiter #(
    .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RESP_DEPTH(2)
  ) u_dut (
    .clk(clk), .rst(rst), .ch_req(req), .ch_wr(wr),
    .ch_wstrb(wstrb), .ch_addr(addr), .ch_wdata(wdata),
    .ch_addr_ok(aok), .ch_data_ok(dok), .ch_rdata(rdata),
    .ch_rready(rready), .mem_en(men), .mem_wen(wen),
    .mem_addr(maddr), .mem_wdata(mwdata), .mem_rdata(mrdata)
  );

  mycpu_sram_arbiter #(
    .NUM_CH(3), .ADDR_W(32), .DATA_W(32), .RESP_DEPTH(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .ch_req(req3), .ch_wr(wr3),
    .ch_wstrb(wstrb3), .ch_addr(addr3), .ch_wdata(wdata3),
    .ch_addr_ok(aok3), .ch_data_ok(dok3), .ch_rdata(rdata3),
    .ch_rready(rready3), .mem_en(men3), .mem_wen(wen3),
    .mem_addr(maddr3), .mem_wdata(mwdata3), .mem_rdata(mrdata3)
  );

  function automatic logic [31:0] sram_fn(input logic [31:0] a);
    return (a == 32'h1000) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
  endfunction

  // SRAM models: read data one cycle after enable.
  always @(posedge clk) begin
    mrdata  <= (men && wen == 4'h0) ? sram_fn(maddr) : 32'h0;
    mrdata3 <= (men3 && wen3 == 4'h0) ? sram_fn(maddr3) : 32'h0;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req, wr;
    logic [3:0]  ws1;
    logic [31:0] a0, a1, wd1;
    logic [1:0]  e_aok, e_dok;
    logic        e_men;
    logic [3:0]  e_wen;
    logic [31:0] e_maddr, e_mwd, e_rd0, e_rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic [1:0] r, w, input logic [3:0] s,
    input logic [31:0] a0, a1, wd,
    input logic [1:0] ea, ed, input logic em, input logic [3:0] ew,
    input logic [31:0] ema, emw, er0, er1);
    vec_t v;
    v.req = r; v.wr = w; v.ws1 = s; v.a0 = a0; v.a1 = a1; v.wd1 = wd;
    v.e_aok = ea; v.e_dok = ed; v.e_men = em; v.e_wen = ew;
    v.e_maddr = ema; v.e_mwd = emw; v.e_rd0 = er0; v.e_rd1 = er1;
    return v;
  endfunction

  vec_t tv [17];

  initial begin
    logic [31:0] q [$];
    logic [31:0] expd;
    int n0;
    int nreq;
    int nrsp;

    tv[0]  = mk(2'b01, 0, 0, 32'h1000, 0, 0, 2'b01, 0, 1, 0, 32'h1000, 0, 0, 0);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[4]  = mk(2'b10, 2'b10, 4'b0011, 0, 32'h2004, 32'h12345678,
                2'b10, 0, 1, 4'b0011, 32'h2004, 32'h12345678, 0, 0);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[6]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    tv[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[8]  = mk(2'b11, 0, 0, 32'h100, 32'h200, 0,
                2'b01, 0, 1, 0, 32'h100, 0, 0, 0);
    tv[9]  = mk(2'b11, 0, 0, 32'h100, 32'h200, 0,
                2'b10, 0, 1, 0, 32'h200, 0, 0, 0);
    tv[10] = mk(2'b11, 0, 0, 32'h100, 32'h200, 0,
                2'b01, 2'b01, 1, 0, 32'h100, 0, 32'h0100C0DE, 0);
    tv[11] = mk(2'b11, 0, 0, 32'h100, 32'h200, 0,
                2'b10, 2'b10, 1, 0, 32'h200, 0, 0, 32'h0200C0DE);
    tv[12] = mk(2'b11, 0, 0, 32'h100, 32'h200, 0,
                2'b01, 2'b01, 1, 0, 32'h100, 0, 32'h0100C0DE, 0);
    tv[13] = mk(2'b11, 0, 0, 32'h100, 32'h200, 0,
                2'b10, 2'b10, 1, 0, 32'h200, 0, 0, 32'h0200C0DE);
    tv[14] = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 32'h0100C0DE, 0);
    tv[15] = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 32'h0200C0DE);
    tv[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    req = 2'b11; wr = 0; rready = 2'b11; wstrb = 0;
    addr = {32'h40, 32'h80}; wdata = 0;
    req3 = 0; wr3 = 0; rready3 = 0; wstrb3 = 0; addr3 = 0; wdata3 = 0;

    step();
    chk("rst_aok", aok, 2'b00);
    chk("rst_dok", dok, 2'b00);
    chk("rst_men", men, 1'b0);
    chk("rst_wen", wen, 4'h0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_dok3", dok3, 3'b000);
    rst = 1'b0;
    req = 2'b00;
    step();

    for (int i = 0; i < 17; i++) begin
      req = tv[i].req; wr = tv[i].wr; rready = 2'b11;
      wstrb = {tv[i].ws1, 4'h0};
      addr  = {tv[i].a1, tv[i].a0};
      wdata = {tv[i].wd1, 32'h0};
      #1;
      chk($sformatf("v%0d_aok", i), aok, tv[i].e_aok);
      chk($sformatf("v%0d_dok", i), dok, tv[i].e_dok);
      chk($sformatf("v%0d_men", i), men, tv[i].e_men);
      chk($sformatf("v%0d_wen", i), wen, tv[i].e_wen);
      chk($sformatf("v%0d_maddr", i), maddr, tv[i].e_maddr);
      chk($sformatf("v%0d_mwd", i), mwdata, tv[i].e_mwd);
      chk($sformatf("v%0d_rd0", i), rdata[31:0], tv[i].e_rd0);
      chk($sformatf("v%0d_rd1", i), rdata[63:32], tv[i].e_rd1);
      step();
    end

    // Back-pressure: ch0 stalls its consumer, ch1 keeps streaming.
    n0 = 0;
    wr = 0; wstrb = 0; wdata = 0; rready = 2'b10;
    for (int c = 0; c < 8; c++) begin
      req = 2'b11;
      addr = {32'h500, 32'h300 + 32'(4 * n0)};
      #1;
      if (aok[0]) n0++;
      if (c >= 4) chk($sformatf("bp_c%0d_aok", c), aok, 2'b10);
      step();
    end
    chk("bp_ch0_grants", n0, 2);

    req = 2'b01; addr = {32'h0, 32'h308}; rready = 2'b11;
    #1;
    chk("drain0_dok", dok[0], 1'b1);
    chk("drain0_rd", rdata[31:0], sram_fn(32'h300));
    chk("drain0_aok", aok, 2'b01);
    step();
    req = 2'b00;
    #1;
    chk("drain1_dok", dok[0], 1'b1);
    chk("drain1_rd", rdata[31:0], sram_fn(32'h304));
    step();
    chk("drain2_dok", dok[0], 1'b1);
    chk("drain2_rd", rdata[31:0], sram_fn(32'h308));
    step();
    chk("drain3_dok", dok[0], 1'b0);
    step();
    step();

    // Reset with one queued and one in-flight response.
    req = 2'b10; addr = {32'h600, 32'h0}; rready = 2'b00;
    #1;
    chk("rs_g1", aok, 2'b10);
    step();
    req = 2'b01; addr = {32'h0, 32'h700};
    #1;
    chk("rs_g0", aok, 2'b01);
    step();
    req = 2'b00;
    #1;
    chk("rs_q1", dok, 2'b10);
    rst = 1'b1;
    #1;
    chk("rs_aok", aok, 2'b00);
    chk("rs_dok", dok, 2'b00);
    chk("rs_men", men, 1'b0);
    chk("rs_rdata", rdata, 64'h0);
    step();
    rst = 1'b0;
    req = 2'b11; addr = {32'h900, 32'h800}; rready = 2'b11;
    #1;
    chk("rs_first_aok", aok, 2'b01);
    chk("rs_first_maddr", maddr, 32'h800);
    chk("rs_first_dok", dok, 2'b00);
    step();
    req = 2'b00;
    #1;
    chk("rs_t1_dok", dok, 2'b00);
    step();
    chk("rs_t2_dok", dok, 2'b01);
    chk("rs_t2_rd", rdata[31:0], sram_fn(32'h800));
    step();

    // Depth-3 streaming on channel 2 with a stalling consumer.
    nreq = 0;
    nrsp = 0;
    for (int cyc = 0; cyc < 200 && nrsp < 10; cyc++) begin
      req3    = {nreq < 10, 2'b00};
      addr3   = {32'h400 + 32'(4 * nreq), 64'h0};
      rready3 = {(cyc % 3) != 0, 2'b00};
      #1;
      if (aok3[2]) begin
        q.push_back(sram_fn(32'h400 + 32'(4 * nreq)));
        nreq++;
      end
      if (dok3[2] && rready3[2]) begin
        expd = (q.size() > 0) ? q.pop_front() : 32'hBAD0BAD0;
        chk($sformatf("s3_rsp%0d", nrsp), rdata3[95:64], expd);
        nrsp++;
      end
      step();
    end
    chk("s3_nrsp", nrsp, 10);
    chk("s3_nreq", nreq, 10);
    #1;
    chk("s3_tail_dok", dok3, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
